bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector: one word in
// flight in the shifter plus one word of look-ahead in a holding register.
module bit_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  seq_out,
    output logic                  seq_valid,
    output logic                  word_done,
    output logic [15:0]           word_cnt
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_full_q, hold_full_d;
    logic                    seq_out_q, seq_out_d;
    logic                    seq_valid_q, seq_valid_d;
    logic                    word_done_q, word_done_d;
    logic [15:0]             word_cnt_q, word_cnt_d;

    logic                    transfer;
    logic                    last_bit;

    assign din_ready = ~hold_full_q;
    assign transfer  = din_valid & ~hold_full_q;
    assign last_bit  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
            word_done_q <= word_done_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Leave SHIFT only when the last bit goes out with nothing queued behind it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit && !hold_full_q && !transfer) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        word_cnt_d  = word_cnt_q;

        if (state_q == IDLE) begin
            if (transfer) begin
                shift_d   = din;
                bit_cnt_d = '0;
            end
        end else if (last_bit) begin
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_d = word_cnt_q + 16'd1;
            end
            bit_cnt_d = '0;
            // A held word takes priority; din_ready is low whenever hold is full.
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else if (transfer) begin
                shift_d = din;
            end else begin
                shift_d = '0;
            end
        end else begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
            end
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (transfer) begin
                hold_d      = din;
                hold_full_d = 1'b1;
            end
        end
    end

    // Outputs are registered copies of what the next cycle will present.
    always_comb begin
        seq_valid_d = (state_d == SHIFT);
        seq_out_d   = 1'b0;
        word_done_d = 1'b0;
        if (seq_valid_d) begin
            seq_out_d   = MSB_FIRST ? shift_d[DATA_WIDTH-1] : shift_d[0];
            word_done_d = (bit_cnt_d == LAST_BIT);
        end
    end

    assign seq_out   = seq_out_q;
    assign seq_valid = seq_valid_q;
    assign word_done = word_done_q;
    assign word_cnt  = word_cnt_q;

endmodule
